// File: rtl/bp_pkg.sv
// Shared types and helpers for the checkpointed global-history branch predictor.
// Struct fields use maximum widths; each instance casts down to its own widths.
package bp_pkg;

    localparam int unsigned IDX_MAX = 16;
    localparam int unsigned CNT_MAX = 4;

    typedef logic [IDX_MAX-1:0] idx_t;
    typedef logic [CNT_MAX-1:0] cnt_t;

    typedef struct packed {
        idx_t idx;
        idx_t ghr;
        logic pred;
    } ckpt_t;

    // Weakly not-taken: 2^(w-1)-1
    function automatic cnt_t cnt_init(int unsigned cnt_w);
        return cnt_t'((32'd1 << (cnt_w - 1)) - 32'd1);
    endfunction

    localparam cnt_t CNT_INIT = cnt_init(2);

    // Concat mode keeps the upper PC bits and replaces the low ghr_w bits with history
    function automatic idx_t pht_index(idx_t pc_hash, idx_t ghr, int unsigned ghr_w,
                                       logic xor_mode);
        idx_t mask;
        mask = idx_t'((32'd1 << ghr_w) - 32'd1);
        if (xor_mode) begin
            return pc_hash ^ ghr;
        end
        return (pc_hash & ~mask) | (ghr & mask);
    endfunction

    function automatic cnt_t sat_update(cnt_t cnt, logic taken, int unsigned cnt_w);
        cnt_t top;
        top = cnt_t'((32'd1 << cnt_w) - 32'd1);
        if (taken) begin
            return (cnt == top) ? cnt : cnt + 1'b1;
        end
        return (cnt == '0) ? cnt : cnt - 1'b1;
    endfunction

endpackage

// File: rtl/bp_ckpt_fifo.sv
// Circular checkpoint buffer for in-flight branches; clear has priority over push/pop.
// A push while full is accepted only when a pop frees the head in the same cycle.
module bp_ckpt_fifo
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   clear,
    input  ckpt_t                  wdata,
    output ckpt_t                  rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PW = $clog2(DEPTH);

    ckpt_t       mem [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [PW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (PW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_q];
    assign count   = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (clear) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_q] <= wdata;
        end
    end

endmodule

// File: rtl/bp_gshare_ckpt.sv
// Global-history predictor: F-stage lookup, D-stage speculative history, M-stage training
// and repair, with a checkpoint FIFO so several unresolved branches can be in flight.
module bp_gshare_ckpt
    import bp_pkg::*;
#(
    parameter int unsigned PHT_DEPTH  = 7,
    parameter int unsigned GHR_WIDTH  = 4,
    parameter int unsigned CNT_WIDTH  = 2,
    parameter int unsigned INDEX_MODE = 1,
    parameter int unsigned CKPT_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [PHT_DEPTH-1:0]        pc_hashF,
    output logic                        pred_takenF,
    input  logic                        branchD,
    input  logic [PHT_DEPTH-1:0]        pc_hashD,
    input  logic                        pred_takenD,
    output logic                        ckpt_full,
    input  logic                        branchM,
    input  logic                        takenM,
    output logic                        mispredictM,
    input  logic                        flush_all,
    output logic [$clog2(CKPT_DEPTH):0] ckpt_count
);

    localparam int unsigned ENTRIES = 1 << PHT_DEPTH;
    localparam logic        XOR_MODE = (INDEX_MODE != 0);

    logic [GHR_WIDTH-1:0] ghr_q, ghr_d, ghr_spec, ghr_fix, head_ghr;
    logic [CNT_WIDTH-1:0] pht_q [ENTRIES];
    logic [PHT_DEPTH-1:0] idx_f, head_idx;
    ckpt_t                head, alloc_entry;
    logic                 fifo_empty, resolve, alloc;
    logic                 fifo_push, fifo_pop, fifo_clear;

    assign idx_f = PHT_DEPTH'(pht_index(idx_t'(pc_hashF), idx_t'(ghr_q), GHR_WIDTH, XOR_MODE));
    assign pred_takenF = pht_q[idx_f][CNT_WIDTH-1];

    assign head_idx    = PHT_DEPTH'(head.idx);
    assign head_ghr    = GHR_WIDTH'(head.ghr);
    assign resolve     = branchM & ~fifo_empty;
    assign mispredictM = resolve & (takenM != head.pred);
    // A full FIFO can still accept a push when a correct resolve frees the head
    assign alloc       = branchD & (~ckpt_full | (resolve & ~mispredictM));

    always_comb begin
        alloc_entry      = '0;
        alloc_entry.idx  = pht_index(idx_t'(pc_hashD), idx_t'(ghr_q), GHR_WIDTH, XOR_MODE);
        alloc_entry.ghr  = idx_t'(ghr_q);
        alloc_entry.pred = pred_takenD;
    end

    if (GHR_WIDTH == 1) begin : g_ghr1
        assign ghr_spec = pred_takenD;
        assign ghr_fix  = takenM;
    end else begin : g_ghrn
        assign ghr_spec = {ghr_q[GHR_WIDTH-2:0], pred_takenD};
        assign ghr_fix  = {head_ghr[GHR_WIDTH-2:0], takenM};
    end

    // flush_all > mispredict repair > normal pop/push
    always_comb begin
        ghr_d      = ghr_q;
        fifo_clear = 1'b0;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        if (flush_all) begin
            fifo_clear = 1'b1;
        end else if (mispredictM) begin
            fifo_clear = 1'b1;
            ghr_d      = ghr_fix;
        end else begin
            fifo_pop  = resolve;
            fifo_push = alloc;
            if (alloc) ghr_d = ghr_spec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    // Training happens on any resolve, including one squashed by flush_all
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                pht_q[i] <= CNT_WIDTH'(cnt_init(CNT_WIDTH));
            end
        end else if (resolve) begin
            pht_q[head_idx] <= CNT_WIDTH'(sat_update(cnt_t'(pht_q[head_idx]), takenM, CNT_WIDTH));
        end
    end

    bp_ckpt_fifo #(
        .DEPTH (CKPT_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .clear (fifo_clear),
        .wdata (alloc_entry),
        .rdata (head),
        .full  (ckpt_full),
        .empty (fifo_empty),
        .count (ckpt_count)
    );

    a_no_alloc_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(branchD && ckpt_full && !(resolve && !mispredictM)))
        else $error("branchD asserted while checkpoint FIFO full");

    a_no_resolve_when_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !(branchM && fifo_empty))
        else $error("branchM asserted with no in-flight branch");

endmodule

// File: tb/tb_bp_gshare_ckpt.sv
// Directed bench for bp_gshare_ckpt; a second instance in concat index mode shares stimulus.
module tb_bp_gshare_ckpt;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] pc_hashF, pc_hashD;
    logic       branchD, pred_takenD, branchM, takenM, flush_all;
    logic       pred_takenF, ckpt_full, mispredictM;
    logic [2:0] ckpt_count;
    logic       pred_takenF0, ckpt_full0, mispredictM0;
    logic [2:0] ckpt_count0;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    bp_gshare_ckpt #(
        .PHT_DEPTH(7), .GHR_WIDTH(4), .CNT_WIDTH(2), .INDEX_MODE(1), .CKPT_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pc_hashF(pc_hashF), .pred_takenF(pred_takenF),
        .branchD(branchD), .pc_hashD(pc_hashD), .pred_takenD(pred_takenD),
        .ckpt_full(ckpt_full), .branchM(branchM), .takenM(takenM),
        .mispredictM(mispredictM), .flush_all(flush_all), .ckpt_count(ckpt_count)
    );

    bp_gshare_ckpt #(
        .PHT_DEPTH(7), .GHR_WIDTH(4), .CNT_WIDTH(2), .INDEX_MODE(0), .CKPT_DEPTH(4)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .pc_hashF(pc_hashF), .pred_takenF(pred_takenF0),
        .branchD(branchD), .pc_hashD(pc_hashD), .pred_takenD(pred_takenD),
        .ckpt_full(ckpt_full0), .branchM(branchM), .takenM(takenM),
        .mispredictM(mispredictM0), .flush_all(flush_all), .ckpt_count(ckpt_count0)
    );

    task automatic drive(input logic bd, input logic [6:0] pcd, input logic pd,
                         input logic bm, input logic tm, input logic fl);
        branchD = bd; pc_hashD = pcd; pred_takenD = pd;
        branchM = bm; takenM = tm; flush_all = fl;
    endtask

    task automatic idle();
        drive(1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [6:0] pcd, input logic pd);
        drive(1'b1, pcd, pd, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        idle();
        pc_hashF = 7'h15;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (pred_takenF !== 1'b0) $display("FAIL reset_pred: got %b want 0", pred_takenF); else passed++;
        total++; if (ckpt_count !== 3'd0) $display("FAIL reset_count: got %0d want 0", ckpt_count); else passed++;
        total++; if (ckpt_full !== 1'b0) $display("FAIL reset_full: got %b want 0", ckpt_full); else passed++;
        total++; if (mispredictM !== 1'b0) $display("FAIL reset_mispredict: got %b want 0", mispredictM); else passed++;
        total++; if (dut.ghr_q !== 4'b0000) $display("FAIL reset_ghr: got %b want 0000", dut.ghr_q); else passed++;
        @(negedge clk) rst_n = 1'b1;
        tick();
    endtask

    task automatic test_warmup();
        pc_hashF = 7'h05;
        for (int k = 0; k < 4; k++) begin
            push(7'h05, 1'b0);
            drive(1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b1);
            #1;
            if (k == 0) begin
                total++; if (mispredictM !== 1'b1) $display("FAIL warmup_mispredict: got %b want 1", mispredictM); else passed++;
            end
            tick();
            idle();
            if (k == 0) begin
                total++; if (pred_takenF !== 1'b1) $display("FAIL warmup_first_pred: got %b want 1", pred_takenF); else passed++;
            end
        end
        #1;
        total++; if (pred_takenF !== 1'b1) $display("FAIL warmup_pred: got %b want 1", pred_takenF); else passed++;
        total++; if (dut.pht_q[5] !== 2'b11) $display("FAIL warmup_saturate: got %b want 11", dut.pht_q[5]); else passed++;
        total++; if (dut.ghr_q !== 4'b0000) $display("FAIL warmup_ghr: got %b want 0000", dut.ghr_q); else passed++;
        total++; if (ckpt_count !== 3'd0) $display("FAIL warmup_count: got %0d want 0", ckpt_count); else passed++;
    endtask

    task automatic test_spec_history();
        push(7'h10, 1'b1);
        push(7'h20, 1'b0);
        push(7'h30, 1'b1);
        total++; if (dut.ghr_q !== 4'b0101) $display("FAIL spec_ghr: got %b want 0101", dut.ghr_q); else passed++;
        total++; if (ckpt_count !== 3'd3) $display("FAIL spec_count: got %0d want 3", ckpt_count); else passed++;
        drive(1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        total++; if (mispredictM !== 1'b0) $display("FAIL spec_mispredict: got %b want 0", mispredictM); else passed++;
        tick();
        idle();
        total++; if (ckpt_count !== 3'd2) $display("FAIL spec_pop_count: got %0d want 2", ckpt_count); else passed++;
        total++; if (dut.ghr_q !== 4'b0101) $display("FAIL spec_pop_ghr: got %b want 0101", dut.ghr_q); else passed++;
        pc_hashF = 7'h15;
        #1;
        total++; if (pred_takenF !== 1'b1) $display("FAIL spec_trained: got %b want 1", pred_takenF); else passed++;
    endtask

    task automatic test_mispredict();
        drive(1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        total++; if (mispredictM !== 1'b1) $display("FAIL mp1_flag: got %b want 1", mispredictM); else passed++;
        tick();
        idle();
        total++; if (dut.ghr_q !== 4'b0011) $display("FAIL mp1_ghr: got %b want 0011", dut.ghr_q); else passed++;
        total++; if (ckpt_count !== 3'd0) $display("FAIL mp1_count: got %0d want 0", ckpt_count); else passed++;
        push(7'h40, 1'b1);
        push(7'h01, 1'b0);
        push(7'h02, 1'b1);
        total++; if (dut.ghr_q !== 4'b1101) $display("FAIL mp2_pre_ghr: got %b want 1101", dut.ghr_q); else passed++;
        drive(1'b0, 7'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        total++; if (mispredictM !== 1'b1) $display("FAIL mp2_flag: got %b want 1", mispredictM); else passed++;
        tick();
        idle();
        total++; if (dut.ghr_q !== 4'b0110) $display("FAIL mp2_ghr: got %b want 0110", dut.ghr_q); else passed++;
        total++; if (ckpt_count !== 3'd0) $display("FAIL mp2_count: got %0d want 0", ckpt_count); else passed++;
        // Retrain idx 0x43 once: decremented counter 00 -> 01 stays not-taken
        push(7'h45, 1'b0);
        drive(1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b1);
        tick();
        idle();
        pc_hashF = 7'h4F;
        #1;
        total++; if (pred_takenF !== 1'b0) $display("FAIL mp2_decrement: got %b want 0", pred_takenF); else passed++;
        total++; if (dut.ghr_q !== 4'b1100) $display("FAIL flush_keeps_ghr: got %b want 1100", dut.ghr_q); else passed++;
    endtask

    task automatic test_full();
        for (int i = 0; i < 4; i++) push(7'(7'h60 + i), 1'b1);
        total++; if (ckpt_count !== 3'd4) $display("FAIL full_count: got %0d want 4", ckpt_count); else passed++;
        total++; if (ckpt_full !== 1'b1) $display("FAIL full_flag: got %b want 1", ckpt_full); else passed++;
        total++; if (dut.ghr_q !== 4'b1111) $display("FAIL full_ghr: got %b want 1111", dut.ghr_q); else passed++;
        drive(1'b1, 7'h64, 1'b0, 1'b1, 1'b1, 1'b0);
        #1;
        total++; if (mispredictM !== 1'b0) $display("FAIL b2b_mispredict: got %b want 0", mispredictM); else passed++;
        tick();
        idle();
        total++; if (ckpt_count !== 3'd4) $display("FAIL b2b_count: got %0d want 4", ckpt_count); else passed++;
        total++; if (ckpt_full !== 1'b1) $display("FAIL b2b_full: got %b want 1", ckpt_full); else passed++;
        total++; if (dut.ghr_q !== 4'b1110) $display("FAIL b2b_ghr: got %b want 1110", dut.ghr_q); else passed++;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 7'h00, 1'b0, 1'b1, 1'b1, 1'b0);
            #1;
            total++; if (mispredictM !== 1'b0) $display("FAIL drain_mispredict%0d: got %b want 0", i, mispredictM); else passed++;
            tick();
            idle();
            total++; if (ckpt_count !== 3'(3 - i)) $display("FAIL drain_count%0d: got %0d want %0d", i, ckpt_count, 3 - i); else passed++;
        end
        drive(1'b0, 7'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        total++; if (mispredictM !== 1'b0) $display("FAIL wrap_entry: got %b want 0", mispredictM); else passed++;
        tick();
        idle();
        total++; if (ckpt_count !== 3'd0) $display("FAIL wrap_count: got %0d want 0", ckpt_count); else passed++;
        total++; if (ckpt_full !== 1'b0) $display("FAIL wrap_full: got %b want 0", ckpt_full); else passed++;
    endtask

    task automatic test_async_reset();
        push(7'h00, 1'b1);
        total++; if (ckpt_count !== 3'd1) $display("FAIL arst_pre_count: got %0d want 1", ckpt_count); else passed++;
        pc_hashF = 7'h05;
        #2 rst_n = 1'b0;
        #1;
        total++; if (ckpt_count !== 3'd0) $display("FAIL arst_count: got %0d want 0", ckpt_count); else passed++;
        total++; if (dut.ghr_q !== 4'b0000) $display("FAIL arst_ghr: got %b want 0000", dut.ghr_q); else passed++;
        total++; if (pred_takenF !== 1'b0) $display("FAIL arst_pht: got %b want 0", pred_takenF); else passed++;
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic test_flush_train();
        push(7'h05, 1'b0);
        drive(1'b1, 7'h33, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        idle();
        total++; if (ckpt_count !== 3'd0) $display("FAIL flush_count: got %0d want 0", ckpt_count); else passed++;
        total++; if (dut.ghr_q !== 4'b0000) $display("FAIL flush_ghr: got %b want 0000", dut.ghr_q); else passed++;
        pc_hashF = 7'h05;
        #1;
        total++; if (pred_takenF !== 1'b1) $display("FAIL flush_trained: got %b want 1", pred_takenF); else passed++;
        pc_hashF = 7'h0A;
        #1;
        total++; if (pred_takenF !== 1'b0) $display("FAIL xor_idx_0a: got %b want 0", pred_takenF); else passed++;
        total++; if (pred_takenF0 !== 1'b1) $display("FAIL concat_idx_0a: got %b want 1", pred_takenF0); else passed++;
        pc_hashF = 7'h1A;
        #1;
        total++; if (pred_takenF0 !== 1'b0) $display("FAIL concat_idx_1a: got %b want 0", pred_takenF0); else passed++;
        total++; if (ckpt_count0 !== 3'd0) $display("FAIL concat_count: got %0d want 0", ckpt_count0); else passed++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_warmup();
        test_spec_history();
        test_mispredict();
        test_full();
        test_async_reset();
        test_flush_train();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/bp_gshare_ckpt.md
Name: bp_gshare_ckpt

Overview:
Parametrised global-history branch predictor. Successor to the single-checkpoint global predictor.
- Index mode is selectable: concatenation or gshare XOR.
- Counter width is configurable.
- A checkpoint FIFO tracks up to CKPT_DEPTH in-flight branches, so several unresolved branches can coexist.
- Lookup happens in F, speculative history update in D, training and misprediction repair in M.

Parameters:
PHT_DEPTH, 7, log2 of PHT entry count; index width.
GHR_WIDTH, 4, global history bits; must be 1..PHT_DEPTH.
CNT_WIDTH, 2, saturating counter width; must be 1..4.
INDEX_MODE, 1, 0 = concat {pc_hash[PHT_DEPTH-1:GHR_WIDTH], GHR}; 1 = pc_hash XOR zero-extended GHR.
CKPT_DEPTH, 4, max unresolved branches; power of two, at least 2.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
pc_hashF  in  PHT_DEPTH  hashed PC of fetch-stage instruction
pred_takenF  out  1  prediction for pc_hashF; combinational
branchD  in  1  decode-stage instruction is a conditional branch; allocate checkpoint
pc_hashD  in  PHT_DEPTH  hashed PC of that branch
pred_takenD  in  1  prediction carried from F for that branch
ckpt_full  out  1  FIFO full; pipeline must stall D and not assert branchD
branchM  in  1  oldest in-flight branch resolves this cycle
takenM  in  1  actual direction
mispredictM  out  1  combinational; branchM & (takenM != stored prediction of oldest entry)
flush_all  in  1  pipeline-wide squash (exception); discards all in-flight branches
ckpt_count  out  log2(CKPT_DEPTH)+1  number of occupied entries

Behaviour:
- Lookup: idx_F = f(pc_hashF, GHR) per INDEX_MODE. pred_takenF = MSB of PHT[idx_F]. Same-cycle combinational read, no latency.
- Reset (async, rst_n=0):
  - GHR = 0; FIFO empty, so ckpt_count = 0 and ckpt_full = 0.
  - Every PHT entry = weakly not-taken, i.e. 2^(CNT_WIDTH-1)-1 (01 for 2-bit).
  - pred_takenF = 0; mispredictM = 0.
  - Reset mid-operation discards all checkpoints immediately.
- Allocate on branchD & !ckpt_full:
  - Push {idx = f(pc_hashD, GHR), ghr = GHR, pred = pred_takenD}.
  - Next cycle GHR = {GHR[GHR_WIDTH-2:0], pred_takenD}. For GHR_WIDTH=1, GHR = pred_takenD.
  - branchD while ckpt_full is a protocol error: ignored, with a simulation assertion.
- Resolve on branchM with the FIFO non-empty:
  - Pop the head entry.
  - Write PHT[head.idx]: increment saturating at 2^CNT_WIDTH-1 if takenM, else decrement saturating at 0.
  - On mispredictM: GHR = {head.ghr[GHR_WIDTH-2:0], takenM}, and flush the whole FIFO. All entries are younger and wrong-path, so ckpt_count becomes 0.
  - branchM with the FIFO empty is ignored: no PHT write, mispredictM = 0, assertion fires.
- Simultaneous events, priority high to low:
  - flush_all: clears FIFO, leaves GHR unchanged. PHT training from a same-cycle branchM still occurs.
  - mispredict recovery: overrides any same-cycle allocate; the D branch is wrong-path and is dropped.
  - Allocate + correct resolve in the same cycle: pop and push together, count unchanged. GHR takes the allocate shift.
- PHT write vs. F read of the same index in the same cycle: the read returns the old value, no bypass.
- FIFO pointers are log2(CKPT_DEPTH) bits and wrap modulo CKPT_DEPTH. Count is tracked separately to tell full from empty.

Decomposition:
- Package bp_pkg holds:
  - ckpt_t struct {idx, ghr, pred}.
  - Function pht_index(pc_hash, ghr, mode).
  - Function sat_update(cnt, taken).
  - Constant CNT_INIT.
- Sub-module bp_ckpt_fifo: parametrised circular buffer with push, pop, clear, full and count. Its width is ckpt_t, its depth CKPT_DEPTH, and it uses the same async active-low reset.
- The top level holds the GHR, the PHT array, and the priority logic.

Test Plan:
- Reset then pc_hashF=7'h15 -> pred_takenF=0, ckpt_count=0, GHR=0.
- Warm-up: four branchD/branchM taken pairs at pc_hashD=7'h05, GHR held at 0 by flush between pairs -> counter 01->10->11->11; pred_takenF=1 for idx 7'h05.
- Speculative history: three branchD pushes with preds 1,0,1 -> GHR=4'b0101, ckpt_count=3. Then branchM takenM=1 matching head -> count=2, GHR unchanged, mispredictM=0.
- Mispredict recovery: head saved ghr=4'b0011, pred=1, takenM=0, two younger entries -> mispredictM=1, next GHR=4'b0110, ckpt_count=0, PHT[head.idx] decremented.
- Full FIFO: CKPT_DEPTH pushes -> ckpt_full=1. Same-cycle correct branchM plus branchD -> count stays CKPT_DEPTH, pointers wrap correctly.
- Concurrency:
  - Async rst_n pulse mid-stream, between clock edges -> outputs reset immediately.
  - flush_all with branchM -> PHT still trained, FIFO empty.
  - INDEX_MODE=0 run -> idx_F = {pc_hash[6:4], GHR}.
